// File: rtl/pmem_line_responder_pkg.sv
// Shared constants and types for the line responder: defaults and FSM states in
// rv32i_types, responder-local op type and address helper in pmem_line_responder_pkg.
package rv32i_types;
   localparam int unsigned S_OFFSET_DEF = 5;
   localparam int unsigned S_LINE_DEF   = 256;
   localparam int unsigned S_DEPTH_DEF  = 4;
   localparam int unsigned LATENCY_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      TURN = 2'd3
   } pmem_state_e;
endpackage

package pmem_line_responder_pkg;
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } pmem_op_e;

   // Any address bit at or above lo_bit makes the access fall outside storage.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned lo_bit);
      return |(addr >> lo_bit);
   endfunction
endpackage

// File: rtl/pmem_line_responder_if.sv
// Line-memory request/response bundle: master is the initiator, slave the responder.
// Requests are levels held until pmem_resp; pmem_resp is a one-cycle completion pulse.
interface pmem_line_responder_if #(
   parameter int unsigned s_line = 256
);
   logic              pmem_read;
   logic              pmem_write;
   logic [31:0]       pmem_addr;
   logic [s_line-1:0] pmem_wdata;
   logic [s_line-1:0] pmem_rdata;
   logic              pmem_resp;
   logic              pmem_error;
   logic              busy;

   modport master (
      output pmem_read, pmem_write, pmem_addr, pmem_wdata,
      input  pmem_rdata, pmem_resp, pmem_error, busy
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
      output pmem_rdata, pmem_resp, pmem_error, busy
   );
endinterface

// File: rtl/pmem_line_responder_line_store.sv
// Line storage: 2**s_depth lines of s_line bits, synchronous write, combinational read.
// Zero latency on read, write lands on the clock edge; contents are never reset.
module line_store #(
   parameter int unsigned s_line  = 256,
   parameter int unsigned s_depth = 4
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [s_depth-1:0] i_widx,
   input  logic [s_line-1:0]  i_wdat,
   input  logic [s_depth-1:0] i_ridx,
   output logic [s_line-1:0]  o_rdat
);
   logic [s_line-1:0] r_mem [0:(1 << s_depth)-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_widx] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_ridx];
endmodule

// File: rtl/pmem_line_responder.sv
// Line-memory responder: accepts one read/write, answers LATENCY cycles later with a resp pulse.
// No backpressure; requests are ignored while busy and for one turnaround cycle after resp.
module pmem_line_responder
   import rv32i_types::*;
   import pmem_line_responder_pkg::*;
#(
   parameter int unsigned s_offset = S_OFFSET_DEF,
   parameter int unsigned s_line   = S_LINE_DEF,
   parameter int unsigned s_depth  = S_DEPTH_DEF,
   parameter int unsigned LATENCY  = LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pmem_line_responder_if.slave bus
);
   localparam int unsigned IDX_LO = s_offset;
   localparam int unsigned IDX_HI = s_offset + s_depth - 1;

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("pmem_line_responder: LATENCY must be within 1..15");
   end
   if (s_line != (8 << s_offset)) begin : g_bad_line
      $error("pmem_line_responder: s_line must equal 8*2**s_offset");
   end

   pmem_state_e        r_state;
   pmem_state_e        w_next_state;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_next;
   pmem_op_e           r_op;
   pmem_op_e           w_sel_op;
   logic [s_depth-1:0] r_idx;
   logic [s_depth-1:0] w_sel_idx;
   logic               r_oor;
   logic               w_sel_oor;
   logic [s_line-1:0]  r_wdata;
   logic [s_line-1:0]  r_rdata;
   logic [s_line-1:0]  w_rd_line;
   logic               w_req;
   logic               w_accept;
   logic               w_enter_resp;
   logic               w_we;
   logic               w_unused_ofs;

   assign w_req        = bus.pmem_read | bus.pmem_write;
   // Byte-offset bits select nothing inside a whole-line access.
   assign w_unused_ofs = ^bus.pmem_addr[s_offset-1:0];

   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_accept     = 1'b1;
               w_cnt_next   = 4'(LATENCY - 1);
               w_next_state = (LATENCY <= 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            w_cnt_next = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_next_state = RESP;
            end
         end
         RESP:    w_next_state = TURN;
         TURN:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Transaction attributes as they will be seen in RESP; with LATENCY=1 that is
   // the request being accepted on this very edge, otherwise the captured one.
   assign w_sel_op     = w_accept ? (bus.pmem_write ? OP_WRITE : OP_READ) : r_op;
   assign w_sel_idx    = w_accept ? bus.pmem_addr[IDX_HI:IDX_LO] : r_idx;
   assign w_sel_oor    = w_accept ? addr_out_of_range(bus.pmem_addr, s_offset + s_depth) : r_oor;
   assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);
   assign w_we         = (r_state == RESP) && (r_op == OP_WRITE) && !r_oor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= OP_READ;
         r_idx   <= '0;
         r_oor   <= 1'b0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_op    <= w_sel_op;
         r_idx   <= w_sel_idx;
         r_oor   <= w_sel_oor;
         r_wdata <= bus.pmem_wdata;
      end
   end

   // Read data is loaded on the edge into RESP and then held until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (w_enter_resp) begin
         if (w_sel_oor) begin
            r_rdata <= '0;
         end else if (w_sel_op == OP_READ) begin
            r_rdata <= w_rd_line;
         end
      end
   end

   line_store #(
      .s_line  (s_line),
      .s_depth (s_depth)
   ) u_line_store (
      .clk    (clk),
      .i_we   (w_we),
      .i_widx (r_idx),
      .i_wdat (r_wdata),
      .i_ridx (w_sel_idx),
      .o_rdat (w_rd_line)
   );

   assign bus.pmem_rdata = r_rdata;
   assign bus.pmem_resp  = (r_state == RESP);
   assign bus.pmem_error = (r_state == RESP) && r_oor;
   assign bus.busy       = (r_state != IDLE);

   a_resp_single: assert property (@(posedge clk) disable iff (!rst_n)
      bus.pmem_resp |=> !bus.pmem_resp);
   a_error_with_resp: assert property (@(posedge clk) disable iff (!rst_n)
      bus.pmem_error |-> bus.pmem_resp);
endmodule

// File: doc/pmem_line_responder.md
PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

Interface
REQ-001 Parameter: s_offset, 5, byte-offset bits per line.
REQ-002 Parameter: s_line, 256, line width in bits (8*2**s_offset).
REQ-003 Parameter: s_depth, 4, line-index bits; storage holds 2**s_depth lines.
REQ-004 Parameter: LATENCY, 4, cycles from request acceptance to pmem_resp (legal range 1..15).
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Port: rst_n  input  1  asynchronous active-low reset.
REQ-008 Port: pmem_read  input  1  line read request, level, held by initiator until pmem_resp.
REQ-009 Port: pmem_write  input  1  line write request, level, held by initiator until pmem_resp.
REQ-010 Port: pmem_addr  input  32  byte address; bits [s_offset-1:0] ignored.
REQ-011 Port: pmem_wdata  input  s_line  full-line write data.
REQ-012 Port: pmem_rdata  output  s_line  registered read data, valid while pmem_resp high.
REQ-013 Port: pmem_resp  output  1  single-cycle completion pulse.
REQ-014 Port: pmem_error  output  1  asserted with pmem_resp when the access was out of range.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, WAIT, RESP, TURN; encoding free.
REQ-017 IDLE: if pmem_write or pmem_read is high, capture pmem_addr, pmem_wdata and op, load counter with LATENCY-1, go to WAIT (LATENCY=1: straight to RESP).
REQ-018 Simultaneous pmem_read and pmem_write in IDLE: write accepted first; the read is accepted as a separate transaction after TURN if still asserted.
REQ-019 WAIT: decrement counter each cycle; at zero go to RESP; requests ignored.
REQ-020 RESP: pmem_resp=1 for exactly this cycle; a write commits the captured line to storage on this edge; a read drives stored line on pmem_rdata.
REQ-021 Total latency: pmem_resp rises exactly LATENCY cycles after the acceptance edge.
REQ-022 TURN: one cycle, requests ignored, then IDLE; prevents re-acceptance of a request still held during the pmem_resp cycle.
REQ-023 Range: line index = addr[s_offset+s_depth-1:s_offset]; any set bit in addr[31:s_offset+s_depth] is out of range.
REQ-024 Out of range: pmem_error=1 with pmem_resp, storage unchanged, pmem_rdata all zeros; same latency as in-range.
REQ-025 Request deasserted during WAIT: transaction still completes, write still commits, pmem_resp still pulses.
REQ-026 Writes replace the whole line; no byte masking.
REQ-027 pmem_rdata holds its last value outside RESP (after a write response: unchanged from prior read).
REQ-028 Read-after-write to same line returns the newly written data.

Reset
REQ-029 rst_n low: state IDLE, counter 0, pmem_resp 0, pmem_error 0, busy 0, pmem_rdata 0, captured registers 0, immediately and asynchronously.
REQ-030 Reset mid-transaction abandons it: no pmem_resp, no storage write.
REQ-031 Storage contents are not reset; simulation initializes all lines to zero.

Structure
REQ-032 Default s_line, s_offset and LATENCY constants and the state enum type live in rv32i_types.
REQ-033 Storage is one sub-module, line_store: 2**s_depth x s_line, synchronous write, combinational read by index.
REQ-034 Control FSM, counter and range check live in pmem_line_responder.

Verification
REQ-035 Reset then read 0x0000_0040 -> pmem_resp at cycle 4 after acceptance, rdata 0, error 0, busy 1 from acceptance until TURN ends.
REQ-036 Write 0x0000_0020 with 256'hA5..A5, then read 0x0000_003F -> second response returns 256'hA5..A5.
REQ-037 pmem_read and pmem_write both high, addr 0x0000_0060, data 256'h1 -> write response first, then read response returning 256'h1, two separate pulses.
REQ-038 Read 0x0000_0200 (out of range at s_depth=4) -> pmem_resp with pmem_error=1, rdata 0; storage unchanged on re-read.
REQ-039 Write accepted, pmem_write dropped after 1 cycle -> pmem_resp still at cycle 4, subsequent read returns written data.
REQ-040 rst_n pulsed low during WAIT of a write -> no pmem_resp, busy 0 immediately, target line keeps old contents.
